uart_rx_fsm: RTL

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx_fsm.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_pkg.sv
// rtl/uart_rx_fsm_pkg.sv - shared UART state encoding, parity codes and oversample default
package uart_rx_fsm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;
   localparam logic [1:0] PAR_INV  = 2'b11;

   localparam int OVERSAMPLE_DEF = 16;

   // The reserved code behaves exactly like "no parity".
   function automatic logic par_enabled(input logic [1:0] par);
      return (par != PAR_NONE) && (par != PAR_INV);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - oversampling UART receiver FSM; break detect under UART_RX_BREAK_DET_EN
module uart_rx_fsm
   import uart_rx_fsm_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic       rxd,
   input  logic       D_num,
   input  logic       S_num,
   input  logic [1:0] Par,
   output logic [7:0] d_out,
   output logic       rx_done,
   output logic       par_err,
   output logic       frm_err,
   output logic       is_active
`ifdef UART_RX_BREAK_DET_EN
   ,
   output logic       break_det
`endif
);

   localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

   uart_state_t   state;
   logic          rxd_s;
   logic          rxd_q;
   logic [TW-1:0] tick_cnt;
   logic [TW-1:0] next_tick;
   logic [2:0]    bit_cnt;
   logic          stop_cnt;
   logic [7:0]    shift;
   logic          d8;
   logic          s2;
   logic [1:0]    par;
   logic          par_acc;
   logic          par_bad;
   logic          frm_bad;
   logic          any_one;
   logic          fall;
   logic          mid_bit;

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rxd),
      .q     (rxd_s)
   );

   assign fall      = rxd_q & ~rxd_s;
   assign mid_bit   = baud_tick && (tick_cnt == LAST_TICK);
   assign next_tick = (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
   assign is_active = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rxd_q    <= 1'b1;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shift    <= '0;
         d8       <= 1'b1;
         s2       <= 1'b0;
         par      <= PAR_NONE;
         par_acc  <= 1'b0;
         par_bad  <= 1'b0;
         frm_bad  <= 1'b0;
         any_one  <= 1'b0;
         d_out    <= '0;
         rx_done  <= 1'b0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         break_det <= 1'b0;
`endif
      end else begin
         rxd_q   <= rxd_s;
         rx_done <= 1'b0;
         case (state)
            IDLE: begin
               // Frame format is frozen here so mid-frame input changes are harmless.
               if (fall) begin
                  state    <= START;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  shift    <= '0;
                  par_acc  <= 1'b0;
                  par_bad  <= 1'b0;
                  frm_bad  <= 1'b0;
                  any_one  <= 1'b0;
                  d8       <= D_num;
                  s2       <= S_num;
                  par      <= Par;
               end
            end
            START: begin
               if (baud_tick) begin
                  if (tick_cnt == HALF_TICK) begin
                     tick_cnt <= '0;
                     state    <= rxd_s ? IDLE : DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (baud_tick) tick_cnt <= next_tick;
               if (mid_bit) begin
                  shift   <= {rxd_s, shift[7:1]};
                  par_acc <= par_acc ^ rxd_s;
                  any_one <= any_one | rxd_s;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == (d8 ? 3'd7 : 3'd6))
                     state <= par_enabled(par) ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (baud_tick) tick_cnt <= next_tick;
               if (mid_bit) begin
                  par_bad <= (par == PAR_ODD) ? ~(par_acc ^ rxd_s) : (par_acc ^ rxd_s);
                  any_one <= any_one | rxd_s;
                  state   <= STOP;
               end
            end
            STOP: begin
               if (baud_tick) tick_cnt <= next_tick;
               if (mid_bit) begin
                  if (s2 && !stop_cnt) begin
                     stop_cnt <= 1'b1;
                     frm_bad  <= frm_bad | ~rxd_s;
                     any_one  <= any_one | rxd_s;
                  end else begin
                     // Leave at mid-stop so the next start edge is caught without slip.
                     state   <= IDLE;
                     rx_done <= 1'b1;
                     d_out   <= d8 ? shift : {1'b0, shift[7:1]};
                     par_err <= par_bad;
                     frm_err <= frm_bad | ~rxd_s;
`ifdef UART_RX_BREAK_DET_EN
                     break_det <= ~(any_one | rxd_s);
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
